iterative_divider: RTL and testbench
====================================

ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 Parameter DIV, 6'b011010, funct code for signed divide.
REQ-002 Parameter DIVU, 6'b011011, funct code for unsigned divide.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a division; sampled on clk rising edge.
REQ-006 Signal  input  6  funct code; only DIV/DIVU are accepted.
REQ-007 dataA  input  32  dividend.
REQ-008 dataB  input  32  divisor.
REQ-009 busy  output  1  high while a division is in progress (RUN state).
REQ-010 done  output  1  one-cycle pulse marking a completed result.
REQ-011 quotient  output  32  LO result; held until the next completion.
REQ-012 remainder  output  32  HI result; held until the next completion.
REQ-013 div_zero  output  1  divisor was zero for the last completed operation.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 and Signal in {DIV, DIVU}, the block SHALL latch dataA, dataB and Signal, and leave IDLE on the same edge; start with any other Signal SHALL be ignored.
REQ-016 start SHALL be ignored in RUN and DONE; operands SHALL NOT be re-latched.
REQ-017 With divisor nonzero: IDLE->RUN; 32 RUN cycles of restoring shift-subtract (one quotient bit per cycle, 6-bit counter 0..31, 33-bit partial remainder); RUN->DONE after count 31.
REQ-018 With divisor zero: IDLE->DONE directly; quotient=32'hFFFFFFFF, remainder=latched dataA, div_zero=1.
REQ-019 quotient, remainder and div_zero SHALL update on the edge that enters DONE; done=1 for exactly that one DONE cycle; DONE->IDLE unconditionally.
REQ-020 Latency: done high in cycle 33 after the accepting edge (nonzero divisor), and in cycle 1 (zero divisor).
REQ-021 busy SHALL be 1 exactly during RUN cycles.
REQ-022 DIVU: operands unsigned; quotient = floor(A/B), remainder = A - quotient*B.
REQ-023 DIV: operate on magnitudes; negate quotient if operand signs differ; remainder sign follows dividend (truncating division).
REQ-024 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give quotient 32'h80000000 and remainder 0, with no flag.
REQ-025 div_zero SHALL be 0 on every nonzero-divisor completion.

Reset
REQ-026 reset=0 SHALL force IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0 and div_zero=0 immediately, independent of clk.
REQ-027 Reset during RUN SHALL abort the operation; no done pulse SHALL follow for it.

Configuration
REQ-028 Macro SIGNED_DIV_EN defined: DIV SHALL behave per REQ-023/024.
REQ-029 Macro SIGNED_DIV_EN undefined: DIV SHALL be accepted and executed identically to DIVU; sign-fix logic SHALL be absent.

Verification
REQ-030 DIVU, A=100, B=7, start one cycle -> busy for 32 cycles, done in cycle 33; quotient=14, remainder=2.
REQ-031 DIV, A=32'hFFFFFFF9 (-7), B=2 -> quotient=32'hFFFFFFFD (-3), remainder=32'hFFFFFFFF (-1). Without SIGNED_DIV_EN -> quotient=32'h7FFFFFFC, remainder=1.
REQ-032 DIVU, A=5, B=0 -> done in cycle 1, busy never high; quotient=32'hFFFFFFFF, remainder=5, div_zero=1. A following DIVU 9/3 -> quotient=3, remainder=0, div_zero=0.
REQ-033 DIV, A=32'h80000000, B=32'hFFFFFFFF -> quotient=32'h80000000, remainder=0, div_zero=0.
REQ-034 DIVU 50/5 running; pulse start with DIVU 8/2 at cycle 5 -> ignored; result quotient=10, remainder=0. start with Signal=6'b100000 in IDLE -> no busy, no done.
REQ-035 DIVU 1000/3, assert reset=0 at cycle 10 -> busy=0 and all outputs 0 immediately; no done after release; the next DIVU 7/7 -> quotient=1, remainder=0.

Source files
------------

// File: rtl/iterative_divider.sv
// Restoring shift-subtract divider: 32 RUN cycles per quotient, zero divisor completes in one cycle.
// Define SIGNED_DIV_EN to give DIV truncating signed semantics; otherwise DIV runs as DIVU.
module iterative_divider #(
    parameter logic [5:0] DIV  = 6'b011010,
    parameter logic [5:0] DIVU = 6'b011011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  Signal,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_next;
    logic [5:0]  count;
    logic [32:0] rem_r;
    logic [31:0] dvd_r;
    logic [31:0] dvs_r;
    logic        accept;
    logic [31:0] mag_a, mag_b;
    logic [32:0] shifted, diff;
    logic [31:0] step_q, step_r;
    logic [31:0] final_q, final_r;

    assign accept = (state == IDLE) && start && ((Signal == DIV) || (Signal == DIVU));

`ifdef SIGNED_DIV_EN
    logic is_signed;
    logic neg_q_r, neg_r_r;
    assign is_signed = (Signal == DIV);
    assign mag_a     = (is_signed && dataA[31]) ? -dataA : dataA;
    assign mag_b     = (is_signed && dataB[31]) ? -dataB : dataB;
    assign final_q   = neg_q_r ? -step_q : step_q;
    assign final_r   = neg_r_r ? -step_r : step_r;
`else
    assign mag_a   = dataA;
    assign mag_b   = dataB;
    assign final_q = step_q;
    assign final_r = step_r;
`endif

    // One restoring step: bring in the next dividend bit, keep the difference if it did not borrow.
    assign shifted = {rem_r[31:0], dvd_r[31]};
    assign diff    = shifted - {1'b0, dvs_r};
    assign step_q  = {dvd_r[30:0], ~diff[32]};
    assign step_r  = diff[32] ? shifted[31:0] : diff[31:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (accept) state_next = (dataB == 32'd0) ? DONE : RUN;
            RUN: begin
                busy = 1'b1;
                if (count == 6'd31) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= 6'd0;
            rem_r     <= 33'd0;
            dvd_r     <= 32'd0;
            dvs_r     <= 32'd0;
            quotient  <= 32'd0;
            remainder <= 32'd0;
            div_zero  <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
`endif
        end else if (accept) begin
            count <= 6'd0;
            rem_r <= 33'd0;
            dvd_r <= mag_a;
            dvs_r <= mag_b;
`ifdef SIGNED_DIV_EN
            neg_q_r <= is_signed && (dataA[31] ^ dataB[31]);
            neg_r_r <= is_signed && dataA[31];
`endif
            if (dataB == 32'd0) begin
                quotient  <= 32'hFFFF_FFFF;
                remainder <= dataA;
                div_zero  <= 1'b1;
            end
        end else if (state == RUN) begin
            count <= count + 6'd1;
            rem_r <= {1'b0, step_r};
            dvd_r <= step_q;
            if (count == 6'd31) begin
                quotient  <= final_q;
                remainder <= final_r;
                div_zero  <= 1'b0;
            end
        end else begin
            count <= 6'd0;
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: latency, busy length, results and flags against hand-computed values.
module tb_iterative_divider;

    localparam logic [5:0] DIV  = 6'b011010;
    localparam logic [5:0] DIVU = 6'b011011;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    iterative_divider dut (
        .clk(clk), .reset(reset), .start(start), .Signal(Signal),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_zero(div_zero),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // driver: present a request for exactly one rising edge
    task automatic launch(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Signal = sig;
        dataA  = a;
        dataB  = b;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done; optionally injects a DIVU 8/2 start at cycle inject_at.
    task automatic wait_done(input int inject_at, output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (cyc == inject_at) begin
                Signal = DIVU; dataA = 32'd8; dataB = 32'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        start = 1'b0;
    endtask

    task automatic run_div(input string tag, input logic [5:0] sig, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input int elat, input int inject_at);
        int cyc, bc;
        exp_q.push_back(eq);
        exp_q.push_back(er);
        exp_q.push_back({31'd0, edz});
        launch(sig, a, b);
        wait_done(inject_at, cyc, bc);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_latency"}, cyc, elat);
        check({tag, "_busy_cycles"}, bc, (elat == 33) ? 32'd32 : 32'd0);
        check({tag, "_quotient"}, quotient, exp_q.pop_front());
        check({tag, "_remainder"}, remainder, exp_q.pop_front());
        check({tag, "_div_zero"}, {31'd0, div_zero}, exp_q.pop_front());
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int seen_busy, seen_done;
        reset = 1'b0; start = 1'b0; Signal = 6'd0; dataA = 32'd0; dataB = 32'd0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_div("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0);
`ifdef SIGNED_DIV_EN
        run_div("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0);
        run_div("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
        run_div("div_m20_m6", DIV, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'd3, 32'hFFFF_FFFE, 1'b0, 33, 0);
`else
        run_div("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 0);
        run_div("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, 0);
`endif
        run_div("divu_5_0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0);
        run_div("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0);
        run_div("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0);
        run_div("divu_3_max", DIVU, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd3, 1'b0, 33, 0);
        run_div("divu_50_5_inject", DIVU, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33, 5);

        // invalid funct code must be ignored
        launch(6'b100000, 32'd12, 32'd4);
        seen_busy = 0; seen_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) seen_busy++;
            if (done) seen_done++;
        end
        check("bad_funct_busy", seen_busy, 32'd0);
        check("bad_funct_done", seen_done, 32'd0);

        // reset mid-run aborts without a done pulse
        launch(DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        check("abort_running", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0; seen_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        check("abort_no_done", seen_done, 32'd0);
        check("abort_no_busy", seen_busy, 32'd0);
        run_div("divu_7_7", DIVU, 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 33, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
